// File: rtl/qam64_symbol_packer_pkg.sv
// qam64_pkg: shared constants and types for the 64-QAM symbol packer.
//   - symbol/axis bit counts
//   - the eight Gray-coded amplitude levels
//   - axis code typedef and shift/count path state encoding
package qam64_pkg;

  localparam int QAM64_BITS_PER_SYM  = 6;
  localparam int QAM64_BITS_PER_AXIS = 3;

  // Amplitude levels on the odd-integer grid
  localparam int QAM64_LVL_M7 = -7;
  localparam int QAM64_LVL_M5 = -5;
  localparam int QAM64_LVL_M3 = -3;
  localparam int QAM64_LVL_M1 = -1;
  localparam int QAM64_LVL_P1 = 1;
  localparam int QAM64_LVL_P3 = 3;
  localparam int QAM64_LVL_P5 = 5;
  localparam int QAM64_LVL_P7 = 7;

  typedef logic [QAM64_BITS_PER_AXIS-1:0] qam64_axis_t;

  // FILL: accumulating bits. STALL: five bits held, output slot occupied.
  typedef enum logic {
    ST_FILL,
    ST_STALL
  } qam64_state_e;

endpackage

// File: rtl/qam64_symbol_packer_if.sv
// qam64_symbol_packer_if: bit-input and symbol-output handshake bundle.
//   bit_in/bit_valid/bit_ready : serial payload bits, MSB-first per symbol
//   flush                      : drop any partially accumulated symbol
//   sym_i/sym_q/sym_valid/sym_ready : mapped constellation point handshake
//   sym_count                  : symbols handed off downstream (wraps)
// slave  = the packer; master = upstream bit source plus downstream sink.
interface qam64_symbol_packer_if #(
  parameter int IQ_W  = 4,
  parameter int CNT_W = 16
);
  logic                   bit_in;
  logic                   bit_valid;
  logic                   bit_ready;
  logic                   flush;
  logic signed [IQ_W-1:0] sym_i;
  logic signed [IQ_W-1:0] sym_q;
  logic                   sym_valid;
  logic                   sym_ready;
  logic [CNT_W-1:0]       sym_count;

  modport slave (
    input  bit_in, bit_valid, flush, sym_ready,
    output bit_ready, sym_i, sym_q, sym_valid, sym_count
  );

  modport master (
    output bit_in, bit_valid, flush, sym_ready,
    input  bit_ready, sym_i, sym_q, sym_valid, sym_count
  );
endinterface

// File: rtl/qam64_symbol_packer_gray_map.sv
// qam64_gray_map: combinational 3-bit Gray code -> signed amplitude.
//   code_i  : axis code (3 bits)
//   level_o : signed two's-complement level, IQ_W bits (IQ_W >= 4)
module qam64_gray_map
  import qam64_pkg::*;
#(
  parameter int IQ_W = 4
) (
  input  qam64_axis_t             code_i,
  output logic signed [IQ_W-1:0]  level_o
);

  always_comb begin
    level_o = '0;
    case (code_i)
      3'b000:  level_o = IQ_W'(QAM64_LVL_M7);
      3'b001:  level_o = IQ_W'(QAM64_LVL_M5);
      3'b011:  level_o = IQ_W'(QAM64_LVL_M3);
      3'b010:  level_o = IQ_W'(QAM64_LVL_M1);
      3'b110:  level_o = IQ_W'(QAM64_LVL_P1);
      3'b111:  level_o = IQ_W'(QAM64_LVL_P3);
      3'b101:  level_o = IQ_W'(QAM64_LVL_P5);
      3'b100:  level_o = IQ_W'(QAM64_LVL_P7);
      default: level_o = '0;
    endcase
  end

endmodule

// File: rtl/qam64_symbol_packer.sv
// qam64_symbol_packer: serial bits -> 64-QAM I/Q symbols.
//   data_clk : sole clock, rising edge
//   rst      : synchronous active-high reset
//   bus      : slave side of qam64_symbol_packer_if (bit input handshake,
//              flush, symbol output handshake, handed-off symbol count)
// Six accepted bits form one symbol; b5b4b3 select I, b2b1b0 select Q.
// The first five bits of a symbol may accumulate while the output is
// stalled; only the completing bit waits for a free output slot.
module qam64_symbol_packer
  import qam64_pkg::*;
#(
  parameter int IQ_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic                  data_clk,
  input  logic                  rst,
  qam64_symbol_packer_if.slave  bus
);

  localparam logic [2:0] CNT_LAST = 3'(QAM64_BITS_PER_SYM - 1);

  // Only b5..b1 need storing: b0 is the completing bit, taken straight
  // from bit_in in the cycle the symbol is mapped.
  logic [QAM64_BITS_PER_SYM-2:0] shift_q, shift_d;
  logic [2:0]                    cnt_q, cnt_d;
  qam64_state_e                  state_q, state_d;
  logic                          sym_valid_q, sym_valid_d;
  logic signed [IQ_W-1:0]        sym_i_q, sym_i_d;
  logic signed [IQ_W-1:0]        sym_q_q, sym_q_d;
  logic [CNT_W-1:0]              sym_count_q, sym_count_d;

  logic                          bit_ready;
  logic                          accept;
  logic                          complete;
  logic                          handoff;
  logic [QAM64_BITS_PER_SYM-1:0] code;
  logic signed [IQ_W-1:0]        lvl_i, lvl_q;

  assign code = {shift_q, bus.bit_in};

  qam64_gray_map #(.IQ_W(IQ_W)) u_map_i (
    .code_i  (code[5:3]),
    .level_o (lvl_i)
  );

  qam64_gray_map #(.IQ_W(IQ_W)) u_map_q (
    .code_i  (code[2:0]),
    .level_o (lvl_q)
  );

  // Next-state and handshake logic
  always_comb begin
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    sym_valid_d = sym_valid_q;
    sym_i_d     = sym_i_q;
    sym_q_d     = sym_q_q;
    sym_count_d = sym_count_q;

    // STALL is exactly (cnt==5 with the output occupied), so the refusal
    // of the completing bit reduces to this state plus sym_ready.
    bit_ready = ~rst & ~bus.flush & ((state_q == ST_FILL) | bus.sym_ready);
    accept    = bus.bit_valid & bit_ready;
    complete  = accept & (cnt_q == CNT_LAST);
    handoff   = sym_valid_q & bus.sym_ready;

    if (bus.flush) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (complete) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (accept) begin
      shift_d = {shift_q[QAM64_BITS_PER_SYM-3:0], bus.bit_in};
      cnt_d   = cnt_q + 3'd1;
    end

    // A load in the handoff cycle keeps valid high with the new data.
    if (complete) begin
      sym_valid_d = 1'b1;
      sym_i_d     = lvl_i;
      sym_q_d     = lvl_q;
    end else if (handoff) begin
      sym_valid_d = 1'b0;
    end

    if (handoff) begin
      sym_count_d = sym_count_q + 1'b1;
    end

    state_d = ((cnt_d == CNT_LAST) && sym_valid_d) ? ST_STALL : ST_FILL;
  end

  always_ff @(posedge data_clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      shift_q     <= '0;
      cnt_q       <= '0;
      sym_valid_q <= 1'b0;
      sym_i_q     <= '0;
      sym_q_q     <= '0;
      sym_count_q <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      sym_valid_q <= sym_valid_d;
      sym_i_q     <= sym_i_d;
      sym_q_q     <= sym_q_d;
      sym_count_q <= sym_count_d;
    end
  end

  assign bus.bit_ready = bit_ready;
  assign bus.sym_valid = sym_valid_q;
  assign bus.sym_i     = sym_i_q;
  assign bus.sym_q     = sym_q_q;
  assign bus.sym_count = sym_count_q;

endmodule

// File: tb/tb_qam64_symbol_packer.sv
// Directed testbench for qam64_symbol_packer. A second instance with an
// 8-bit symbol counter shares the same input stream so counter wrap can
// be reached within a short run.
module tb_qam64_symbol_packer;

  localparam logic signed [3:0] M7 = -4'sd7;
  localparam logic signed [3:0] M5 = -4'sd5;
  localparam logic signed [3:0] M3 = -4'sd3;
  localparam logic signed [3:0] M1 = -4'sd1;
  localparam logic signed [3:0] P1 = 4'sd1;
  localparam logic signed [3:0] P3 = 4'sd3;
  localparam logic signed [3:0] P5 = 4'sd5;
  localparam logic signed [3:0] P7 = 4'sd7;

  // Level by binary code value: 000,001,010,011,100,101,110,111
  logic signed [3:0] tab [8] = '{M7, M5, M1, M3, P7, P5, P1, P3};

  logic data_clk = 1'b0;
  logic rst      = 1'b1;
  int   errors   = 0;
  int   checks   = 0;

  always #5 data_clk = ~data_clk;

  qam64_symbol_packer_if #(.IQ_W(4), .CNT_W(16)) bus ();
  qam64_symbol_packer_if #(.IQ_W(4), .CNT_W(8))  bus8 ();

  assign bus8.bit_in    = bus.bit_in;
  assign bus8.bit_valid = bus.bit_valid;
  assign bus8.flush     = bus.flush;
  assign bus8.sym_ready = bus.sym_ready;

  qam64_symbol_packer #(.IQ_W(4), .CNT_W(16)) dut (
    .data_clk (data_clk),
    .rst      (rst),
    .bus      (bus.slave)
  );

  qam64_symbol_packer #(.IQ_W(4), .CNT_W(8)) dut8 (
    .data_clk (data_clk),
    .rst      (rst),
    .bus      (bus8.slave)
  );

  task automatic tick();
    @(posedge data_clk);
    #1;
  endtask

  task automatic idle();
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
  endtask

  task automatic send_code(input logic [5:0] c);
    for (int j = 5; j >= 0; j--) begin
      bus.bit_valid = 1'b1;
      bus.bit_in    = c[j];
      tick();
    end
  endtask

  task automatic do_reset();
    idle();
    bus.flush = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    bus.flush     = 1'b0;
    bus.sym_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.sym_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bus.sym_valid); end
    checks++; if (bus.sym_i !== 4'sd0) begin errors++; $display("FAIL reset_i got=%0d want=0", bus.sym_i); end
    checks++; if (bus.sym_q !== 4'sd0) begin errors++; $display("FAIL reset_q got=%0d want=0", bus.sym_q); end
    checks++; if (bus.sym_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", bus.sym_count); end
    checks++; if (bus.bit_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_hi got=%b want=0", bus.bit_ready); end
    rst = 1'b0;
    #1;
    checks++; if (bus.bit_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got=%b want=1", bus.bit_ready); end
    tick();
  endtask

  task automatic test_first_symbol();
    do_reset();
    bus.sym_ready = 1'b1;
    send_code(6'b000010);
    checks++; if (bus.sym_valid !== 1'b1) begin errors++; $display("FAIL first_valid got=%b want=1", bus.sym_valid); end
    checks++; if (bus.sym_i !== M7) begin errors++; $display("FAIL first_i got=%0d want=-7", bus.sym_i); end
    checks++; if (bus.sym_q !== M1) begin errors++; $display("FAIL first_q got=%0d want=-1", bus.sym_q); end
    idle();
    tick();
    checks++; if (bus.sym_count !== 16'd1) begin errors++; $display("FAIL first_count got=%0d want=1", bus.sym_count); end
    checks++; if (bus.sym_valid !== 1'b0) begin errors++; $display("FAIL first_clear got=%b want=0", bus.sym_valid); end
  endtask

  task automatic test_all_codes();
    logic [5:0] c;
    do_reset();
    bus.sym_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      c = 6'(k);
      for (int j = 5; j >= 0; j--) begin
        bus.bit_valid = 1'b1;
        bus.bit_in    = c[j];
        #1;
        checks++; if (bus.bit_ready !== 1'b1) begin errors++; $display("FAIL all_ready code=%0d bit=%0d got=%b want=1", k, j, bus.bit_ready); end
        tick();
        if (j == 5 && k > 0) begin
          checks++; if (bus.sym_valid !== 1'b0) begin errors++; $display("FAIL all_handoff code=%0d got=%b want=0", k, bus.sym_valid); end
        end
      end
      checks++;
      if (bus.sym_valid !== 1'b1 || bus.sym_i !== tab[c[5:3]] || bus.sym_q !== tab[c[2:0]]) begin
        errors++;
        $display("FAIL all_sym code=%0d got v=%b i=%0d q=%0d want v=1 i=%0d q=%0d",
                 k, bus.sym_valid, bus.sym_i, bus.sym_q, tab[c[5:3]], tab[c[2:0]]);
      end
    end
    idle();
    tick();
    checks++; if (bus.sym_count !== 16'd64) begin errors++; $display("FAIL all_count got=%0d want=64", bus.sym_count); end
  endtask

  task automatic test_stall();
    logic [5:0] c;
    do_reset();
    bus.sym_ready = 1'b1;
    send_code(6'b100111);
    bus.sym_ready = 1'b0;
    checks++; if (bus.sym_valid !== 1'b1 || bus.sym_i !== P7 || bus.sym_q !== P3) begin errors++; $display("FAIL stall_load got v=%b i=%0d q=%0d want v=1 i=7 q=3", bus.sym_valid, bus.sym_i, bus.sym_q); end
    c = 6'b010110;
    for (int j = 5; j >= 1; j--) begin
      bus.bit_valid = 1'b1;
      bus.bit_in    = c[j];
      #1;
      checks++; if (bus.bit_ready !== 1'b1) begin errors++; $display("FAIL stall_accum bit=%0d got=%b want=1", j, bus.bit_ready); end
      tick();
    end
    bus.bit_in = c[0];
    #1;
    checks++; if (bus.bit_ready !== 1'b0) begin errors++; $display("FAIL stall_block got=%b want=0", bus.bit_ready); end
    for (int n = 0; n < 2; n++) begin
      tick();
      checks++; if (bus.sym_valid !== 1'b1 || bus.sym_i !== P7 || bus.sym_q !== P3 || bus.sym_count !== 16'd0) begin errors++; $display("FAIL stall_hold got v=%b i=%0d q=%0d cnt=%0d want v=1 i=7 q=3 cnt=0", bus.sym_valid, bus.sym_i, bus.sym_q, bus.sym_count); end
    end
    bus.sym_ready = 1'b1;
    #1;
    checks++; if (bus.bit_ready !== 1'b1) begin errors++; $display("FAIL stall_release got=%b want=1", bus.bit_ready); end
    tick();
    checks++; if (bus.sym_valid !== 1'b1 || bus.sym_i !== M1 || bus.sym_q !== P1 || bus.sym_count !== 16'd1) begin errors++; $display("FAIL stall_next got v=%b i=%0d q=%0d cnt=%0d want v=1 i=-1 q=1 cnt=1", bus.sym_valid, bus.sym_i, bus.sym_q, bus.sym_count); end
    idle();
    tick();
    checks++; if (bus.sym_valid !== 1'b0 || bus.sym_count !== 16'd2) begin errors++; $display("FAIL stall_drain got v=%b cnt=%0d want v=0 cnt=2", bus.sym_valid, bus.sym_count); end
  endtask

  task automatic test_flush();
    do_reset();
    bus.sym_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      bus.bit_valid = 1'b1;
      bus.bit_in    = 1'b1;
      tick();
    end
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.bit_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b want=0", bus.bit_ready); end
    tick();
    bus.flush = 1'b0;
    send_code(6'b110101);
    checks++; if (bus.sym_valid !== 1'b1 || bus.sym_i !== P1 || bus.sym_q !== P5) begin errors++; $display("FAIL flush_sym got v=%b i=%0d q=%0d want v=1 i=1 q=5", bus.sym_valid, bus.sym_i, bus.sym_q); end
    // Flush with a symbol pending must leave the output alone
    for (int j = 0; j < 2; j++) begin
      bus.bit_valid = 1'b1;
      bus.bit_in    = 1'b0;
      tick();
    end
    idle();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++; if (bus.sym_valid !== 1'b1 || bus.sym_i !== P1 || bus.sym_q !== P5 || bus.sym_count !== 16'd0) begin errors++; $display("FAIL flush_keep got v=%b i=%0d q=%0d cnt=%0d want v=1 i=1 q=5 cnt=0", bus.sym_valid, bus.sym_i, bus.sym_q, bus.sym_count); end
    bus.sym_ready = 1'b1;
    tick();
    checks++; if (bus.sym_valid !== 1'b0 || bus.sym_count !== 16'd1) begin errors++; $display("FAIL flush_drain got v=%b cnt=%0d want v=0 cnt=1", bus.sym_valid, bus.sym_count); end
    // Flush coinciding with the completing bit: bit refused, count cleared
    for (int j = 0; j < 5; j++) begin
      bus.bit_valid = 1'b1;
      bus.bit_in    = 1'b1;
      tick();
    end
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.bit_ready !== 1'b0) begin errors++; $display("FAIL flush_last_ready got=%b want=0", bus.bit_ready); end
    tick();
    bus.flush = 1'b0;
    checks++; if (bus.sym_valid !== 1'b0) begin errors++; $display("FAIL flush_last_novalid got=%b want=0", bus.sym_valid); end
    send_code(6'b000000);
    checks++; if (bus.sym_valid !== 1'b1 || bus.sym_i !== M7 || bus.sym_q !== M7) begin errors++; $display("FAIL flush_last_sym got v=%b i=%0d q=%0d want v=1 i=-7 q=-7", bus.sym_valid, bus.sym_i, bus.sym_q); end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [3:0] part;
    do_reset();
    bus.sym_ready = 1'b1;
    send_code(6'b000000);
    idle();
    tick();
    checks++; if (bus.sym_count !== 16'd1) begin errors++; $display("FAIL rmid_pre_count got=%0d want=1", bus.sym_count); end
    bus.sym_ready = 1'b0;
    send_code(6'b111111);
    part = 4'b0101;
    for (int j = 3; j >= 0; j--) begin
      bus.bit_valid = 1'b1;
      bus.bit_in    = part[j];
      tick();
    end
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.sym_valid !== 1'b0 || bus.sym_count !== 16'd0 || bus.sym_i !== 4'sd0) begin errors++; $display("FAIL rmid_clear got v=%b cnt=%0d i=%0d want v=0 cnt=0 i=0", bus.sym_valid, bus.sym_count, bus.sym_i); end
    bus.sym_ready = 1'b1;
    send_code(6'b001101);
    checks++; if (bus.sym_valid !== 1'b1 || bus.sym_i !== M5 || bus.sym_q !== P5) begin errors++; $display("FAIL rmid_sym got v=%b i=%0d q=%0d want v=1 i=-5 q=5", bus.sym_valid, bus.sym_i, bus.sym_q); end
    idle();
    tick();
    checks++; if (bus.sym_count !== 16'd1) begin errors++; $display("FAIL rmid_count got=%0d want=1", bus.sym_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.sym_ready = 1'b1;
    for (int s = 0; s < 255; s++) send_code(6'(s));
    idle();
    tick();
    checks++; if (bus8.sym_count !== 8'hFF) begin errors++; $display("FAIL wrap_pre8 got=%0d want=255", bus8.sym_count); end
    checks++; if (bus.sym_count !== 16'd255) begin errors++; $display("FAIL wrap_pre16 got=%0d want=255", bus.sym_count); end
    send_code(6'b101010);
    checks++; if (bus8.sym_i !== P5 || bus8.sym_q !== M1) begin errors++; $display("FAIL wrap_sym got i=%0d q=%0d want i=5 q=-1", bus8.sym_i, bus8.sym_q); end
    idle();
    tick();
    checks++; if (bus8.sym_count !== 8'h00) begin errors++; $display("FAIL wrap_8 got=%0d want=0", bus8.sym_count); end
    checks++; if (bus.sym_count !== 16'd256) begin errors++; $display("FAIL wrap_16 got=%0d want=256", bus.sym_count); end
  endtask

  initial begin
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.sym_ready = 1'b0;
    test_reset();
    test_first_symbol();
    test_all_codes();
    test_stall();
    test_flush();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
